cache_wb: RTL and testbench
===========================

CACHE_WB -- requirements
Module: cache_wb

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 30, giving the processor word-address width in bits.
REQ-002 The block SHALL have parameter SET_BITS, default 2, giving the set index width; sets = 2**SET_BITS, legal range 1..6.
REQ-003 The block SHALL have parameter WAYS, default 2, giving associativity; legal values 1, 2, 4.
REQ-004 The block SHALL have these ports:
 clk  in  1  sole clock, rising edge
 proc_reset_n  in  1  asynchronous active-low reset
 proc_read  in  1  read request
 proc_write  in  1  write request
 proc_addr  in  ADDR_W  word address; [1:0] word offset, [SET_BITS+1:2] index, upper bits tag
 proc_wdata  in  32  write data
 proc_rdata  out  32  read data
 proc_stall  out  1  request not complete
 mem_read  out  1  line read request
 mem_write  out  1  line write request
 mem_addr  out  ADDR_W-2  line address
 mem_wdata  out  128  line write data
 mem_rdata  in  128  line read data
 mem_ready  in  1  memory completes current request, one-cycle pulse

Function
REQ-005 Line SHALL be 4 words; word k occupies line bits [32k+31:32k].
REQ-006 Each way SHALL hold valid, dirty, tag and 128-bit data; each set SHALL hold a log2(WAYS)-bit FIFO victim pointer.
REQ-007 States SHALL be IDLE, WRITEBACK, ALLOCATE.
REQ-008 IDLE read hit: proc_rdata = hit word, proc_stall=0 in the same cycle; no state change.
REQ-009 IDLE write hit: proc_stall=0; the word SHALL be written and dirty set at the next edge; no memory access (write-back).
REQ-010 IDLE miss: proc_stall=1; victim = way at FIFO pointer; victim valid and dirty -> WRITEBACK, otherwise -> ALLOCATE.
REQ-011 WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim data, held stable until mem_ready; on mem_ready -> ALLOCATE.
REQ-012 ALLOCATE: mem_read=1, mem_addr=proc_addr[ADDR_W-1:2] until mem_ready.
REQ-013 On mem_ready in ALLOCATE: victim way gets mem_rdata with, on write, proc_wdata merged at offset; valid=1; tag set; dirty=proc_write; FIFO pointer increments modulo WAYS; return to IDLE.
REQ-014 On the ALLOCATE mem_ready cycle, proc_stall=0, and for a read proc_rdata = addressed word of mem_rdata.
REQ-015 mem_read and mem_write SHALL never be high together; both SHALL be low in IDLE.
REQ-016 Processor SHALL hold proc_addr/proc_wdata/request stable while proc_stall=1; proc_read and proc_write both high SHALL be treated as a write.
REQ-017 No request in IDLE: stall=0, rdata=0, memory outputs 0.
REQ-018 proc_rdata SHALL be 0 whenever no read completes that cycle.

Reset
REQ-019 proc_reset_n low SHALL immediately force state IDLE, all valid/dirty bits 0, FIFO pointers 0, all outputs 0, including mid-WRITEBACK/ALLOCATE; the in-flight memory request is abandoned.
REQ-020 Tags and data need not be reset.

Configuration
REQ-021 With CACHE_STATS_EN defined: ports hit_cnt and miss_cnt (out, 32 each) SHALL count completed IDLE hits and misses entering WRITEBACK/ALLOCATE, wrap at 2**32, and reset to 0.
REQ-022 Without CACHE_STATS_EN, those ports and counters SHALL be absent and behaviour is otherwise identical.

Verification
REQ-023 After reset, read addr 0x10 -> stall, mem_read, mem_addr 0x4; mem_ready with mem_rdata word0=0xA5 -> rdata 0xA5, stall drops that cycle.
REQ-024 Write 0xDEAD to cached addr 0x11 -> stall=0, no mem_write; subsequent read 0x11 -> 0xDEAD with no stall.
REQ-025 WAYS=2: fill set 0 with tags 1 and 2, dirty tag 1, access tag 3 -> mem_write of tag-1 line first, then mem_read of tag 3.
REQ-026 Assert proc_reset_n low during ALLOCATE -> mem_read drops asynchronously; re-read misses.
REQ-027 CACHE_STATS_EN: 3 hits and 2 misses -> hit_cnt=3, miss_cnt=2.

Source files
------------

// File: rtl/cache_wb.sv
// cache_wb: set-associative write-back data cache between a word-addressed
// processor port and a line-addressed memory port. Lines are 4 x 32-bit words.
// Replacement is FIFO per set. A miss on a dirty victim writes the victim line
// back first and then reads the new line.
//
// Ports
//   clk            clock, rising edge
//   proc_reset_n   asynchronous active-low reset
//   proc_read      processor read request
//   proc_write     processor write request (wins if both are high)
//   proc_addr      word address: [1:0] word offset, [SET_BITS+1:2] set index,
//                  upper bits tag
//   proc_wdata     processor write data
//   proc_rdata     read data, zero unless a read completes this cycle
//   proc_stall     request not complete this cycle
//   mem_read       line read request
//   mem_write      line write request
//   mem_addr       line address
//   mem_wdata      line write data
//   mem_rdata      line read data
//   mem_ready      one-cycle completion pulse from memory
//   hit_cnt        completed hits (only with CACHE_STATS_EN defined)
//   miss_cnt       misses leaving IDLE (only with CACHE_STATS_EN defined)
//
// Build option: define CACHE_STATS_EN to add the hit/miss counters.
//
// state     | meaning
// IDLE      | lookup; hits complete in the same cycle
// WRITEBACK | dirty victim line being written to memory
// ALLOCATE  | requested line being read from memory into the victim way
module cache_wb #(
  parameter int ADDR_W   = 30,
  parameter int SET_BITS = 2,
  parameter int WAYS     = 2
) (
  input  logic              clk,
  input  logic              proc_reset_n,
  input  logic              proc_read,
  input  logic              proc_write,
  input  logic [ADDR_W-1:0] proc_addr,
  input  logic [31:0]       proc_wdata,
  output logic [31:0]       proc_rdata,
  output logic              proc_stall,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [127:0]      mem_wdata,
  input  logic [127:0]      mem_rdata,
  input  logic              mem_ready
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int SETS     = 1 << SET_BITS;
  localparam int TAG_W    = ADDR_W - 2 - SET_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state_q, state_d;

  logic                valid_q [SETS][WAYS];
  logic                dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]    tag_q   [SETS][WAYS];
  logic [127:0]        data_q  [SETS][WAYS];
  logic [WAY_BITS-1:0] fifo_q  [SETS];

  logic [SET_BITS-1:0] idx;
  logic [TAG_W-1:0]    tag_in;
  logic [6:0]          word_lsb;
  logic                req, is_write, is_read;
  logic                hit;
  logic [WAY_BITS-1:0] hit_way, victim_way;
  logic [127:0]        hit_line, wr_line, alloc_line;
  logic [31:0]         hit_word;
  logic                idle_hit_wr, alloc_done;

  assign idx      = proc_addr[SET_BITS+1:2];
  assign tag_in   = proc_addr[ADDR_W-1:SET_BITS+2];
  assign word_lsb = {proc_addr[1:0], 5'b0};
  assign req      = proc_read | proc_write;
  assign is_write = proc_write;
  assign is_read  = proc_read & ~proc_write;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag_in)) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
    end
  end

  assign victim_way = fifo_q[idx];
  assign hit_line   = data_q[idx][hit_way];
  assign hit_word   = hit_line[word_lsb +: 32];

  // Line images with the processor word merged at the addressed offset.
  always_comb begin
    wr_line                  = hit_line;
    wr_line[word_lsb +: 32]  = proc_wdata;
    alloc_line               = mem_rdata;
    if (is_write) begin
      alloc_line[word_lsb +: 32] = proc_wdata;
    end
  end

  assign idle_hit_wr = (state_q == IDLE) && is_write && hit;
  assign alloc_done  = (state_q == ALLOCATE) && mem_ready;

  // State register
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req && !hit) begin
          if (valid_q[idx][victim_way] && dirty_q[idx][victim_way]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: if (mem_ready) state_d = ALLOCATE;
      ALLOCATE:  if (mem_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic; everything is held at zero while reset is asserted so an
  // in-flight memory request is dropped immediately.
  always_comb begin
    proc_rdata = '0;
    proc_stall = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (proc_reset_n) begin
      case (state_q)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (is_read) proc_rdata = hit_word;
            end else begin
              proc_stall = 1'b1;
            end
          end
        end
        WRITEBACK: begin
          proc_stall = 1'b1;
          mem_write  = 1'b1;
          mem_addr   = {tag_q[idx][victim_way], idx};
          mem_wdata  = data_q[idx][victim_way];
        end
        ALLOCATE: begin
          mem_read   = 1'b1;
          mem_addr   = proc_addr[ADDR_W-1:2];
          proc_stall = ~mem_ready;
          if (mem_ready && is_read) proc_rdata = mem_rdata[word_lsb +: 32];
        end
        default: ;
      endcase
    end
  end

  // Valid/dirty bits and FIFO pointers
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      for (int s = 0; s < SETS; s++) begin
        fifo_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (idle_hit_wr) begin
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (alloc_done) begin
        valid_q[idx][victim_way] <= 1'b1;
        dirty_q[idx][victim_way] <= is_write;
        fifo_q[idx] <= (WAYS == 1) ? '0 : fifo_q[idx] + 1'b1;
      end
    end
  end

  // Tag and data storage carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (idle_hit_wr) begin
      data_q[idx][hit_way] <= wr_line;
    end
    if (alloc_done) begin
      data_q[idx][victim_way] <= alloc_line;
      tag_q[idx][victim_way]  <= tag_in;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge proc_reset_n) begin
    if (!proc_reset_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state_q == IDLE) && req) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_wb.sv
module tb_cache_wb;

  logic         clk = 1'b0;
  logic         proc_reset_n;
  logic         proc_read, proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read, mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ready;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt, miss_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [127:0] L1 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h000000A5};
  localparam logic [127:0] L2 = {32'h00000203, 32'h00000202, 32'h00000201, 32'h00000200};
  localparam logic [127:0] L3 = {32'h00000303, 32'h00000302, 32'h00000301, 32'h00000300};
  localparam logic [127:0] WB = {32'h0000BEEF, 32'h22222222, 32'h0000DEAD, 32'h000000A5};

  cache_wb #(.ADDR_W(30), .SET_BITS(2), .WAYS(2)) dut (
    .clk          (clk),
    .proc_reset_n (proc_reset_n),
    .proc_read    (proc_read),
    .proc_write   (proc_write),
    .proc_addr    (proc_addr),
    .proc_wdata   (proc_wdata),
    .proc_rdata   (proc_rdata),
    .proc_stall   (proc_stall),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .mem_ready    (mem_ready)
`ifdef CACHE_STATS_EN
    ,
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge, then settle before checks.
  task automatic step(input logic rd, input logic wr, input logic [29:0] a,
                      input logic [31:0] wd, input logic rdy, input logic [127:0] rdat);
    @(negedge clk);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    mem_ready  = rdy;
    mem_rdata  = rdat;
    #1;
  endtask

  initial begin
    proc_reset_n = 1'b0;
    proc_read    = 1'b1;
    proc_write   = 1'b0;
    proc_addr    = 30'h10;
    proc_wdata   = '0;
    mem_ready    = 1'b0;
    mem_rdata    = '0;
    #2;
    chk("rst_stall", proc_stall, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdata", proc_rdata, 0);
    @(negedge clk);
    proc_reset_n = 1'b1;
    proc_read    = 1'b0;

    // Cold read miss at 0x10, line 0x4
    step(1, 0, 30'h10, 0, 0, 0);
    chk("miss_stall", proc_stall, 1);
    chk("miss_idle_mem_read", mem_read, 0);
    chk("miss_idle_mem_write", mem_write, 0);
    step(1, 0, 30'h10, 0, 0, 0);
    chk("alloc_mem_read", mem_read, 1);
    chk("alloc_mem_addr", mem_addr, 28'h4);
    chk("alloc_stall", proc_stall, 1);
    chk("alloc_no_write", mem_write, 0);
    step(1, 0, 30'h10, 0, 1, L1);
    chk("alloc_done_rdata", proc_rdata, 32'hA5);
    chk("alloc_done_stall", proc_stall, 0);

    // Hits, write-back writes, read+write treated as write
    step(1, 0, 30'h12, 0, 0, 0);
    chk("hit_rd_w2", proc_rdata, 32'h22222222);
    chk("hit_rd_stall", proc_stall, 0);
    chk("hit_rd_no_mem", mem_read, 0);
    step(0, 1, 30'h11, 32'hDEAD, 0, 0);
    chk("hit_wr_stall", proc_stall, 0);
    chk("hit_wr_no_mem_write", mem_write, 0);
    chk("hit_wr_rdata", proc_rdata, 0);
    step(1, 0, 30'h11, 0, 0, 0);
    chk("rd_after_wr", proc_rdata, 32'hDEAD);
    chk("rd_after_wr_stall", proc_stall, 0);
    step(1, 1, 30'h13, 32'hBEEF, 0, 0);
    chk("rdwr_rdata", proc_rdata, 0);
    chk("rdwr_stall", proc_stall, 0);
    step(1, 0, 30'h13, 0, 0, 0);
    chk("rd_after_rdwr", proc_rdata, 32'hBEEF);
    step(0, 0, 30'h0, 0, 0, 0);
    chk("noreq_stall", proc_stall, 0);
    chk("noreq_rdata", proc_rdata, 0);
    chk("noreq_mem_addr", mem_addr, 0);

    // Tag 2 into way 1 of set 0 (clean victim, straight to allocate)
    step(1, 0, 30'h20, 0, 0, 0);
    chk("t2_stall", proc_stall, 1);
    step(1, 0, 30'h20, 0, 0, 0);
    chk("t2_mem_read", mem_read, 1);
    chk("t2_mem_write", mem_write, 0);
    chk("t2_mem_addr", mem_addr, 28'h8);
    step(1, 0, 30'h20, 0, 1, L2);
    chk("t2_rdata", proc_rdata, 32'h200);
    chk("t2_stall_drop", proc_stall, 0);

    // Tag 3 write miss evicts dirty tag 1 line
    step(0, 1, 30'h32, 32'hCAFE, 0, 0);
    chk("t3_stall", proc_stall, 1);
    chk("t3_idle_mem_write", mem_write, 0);
    step(0, 1, 30'h32, 32'hCAFE, 0, 0);
    chk("wb_mem_write", mem_write, 1);
    chk("wb_mem_read", mem_read, 0);
    chk("wb_mem_addr", mem_addr, 28'h4);
    chk("wb_mem_wdata", mem_wdata, WB);
    chk("wb_stall", proc_stall, 1);
    step(0, 1, 30'h32, 32'hCAFE, 1, 0);
    chk("wb_ready_mem_write", mem_write, 1);
    chk("wb_ready_wdata", mem_wdata, WB);
    chk("wb_ready_stall", proc_stall, 1);
    step(0, 1, 30'h32, 32'hCAFE, 0, 0);
    chk("t3_alloc_read", mem_read, 1);
    chk("t3_alloc_write", mem_write, 0);
    chk("t3_alloc_addr", mem_addr, 28'hC);
    step(0, 1, 30'h32, 32'hCAFE, 1, L3);
    chk("t3_done_stall", proc_stall, 0);
    chk("t3_done_rdata", proc_rdata, 0);
    step(1, 0, 30'h32, 0, 0, 0);
    chk("t3_merged", proc_rdata, 32'hCAFE);
    chk("t3_merged_stall", proc_stall, 0);
    step(1, 0, 30'h31, 0, 0, 0);
    chk("t3_fill_word", proc_rdata, 32'h301);
    step(1, 0, 30'h21, 0, 0, 0);
    chk("t2_still_hit", proc_rdata, 32'h201);
    chk("t2_still_hit_stall", proc_stall, 0);
    step(0, 0, 30'h0, 0, 0, 0);
`ifdef CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, 32'd8);
    chk("miss_cnt", miss_cnt, 32'd3);
`endif

    // Reset in the middle of an allocate
    step(1, 0, 30'h40, 0, 0, 0);
    chk("t4_stall", proc_stall, 1);
    step(1, 0, 30'h40, 0, 0, 0);
    chk("t4_alloc_read", mem_read, 1);
    chk("t4_alloc_addr", mem_addr, 28'h10);
    #1;
    proc_reset_n = 1'b0;
    #1;
    chk("rst_async_mem_read", mem_read, 0);
    chk("rst_async_stall", proc_stall, 0);
    chk("rst_async_mem_addr", mem_addr, 0);
`ifdef CACHE_STATS_EN
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
`endif
    @(negedge clk);
    proc_reset_n = 1'b1;
    step(1, 0, 30'h30, 0, 0, 0);
    chk("rereaad_miss_stall", proc_stall, 1);
    step(1, 0, 30'h30, 0, 0, 0);
    chk("reread_alloc", mem_read, 1);
    chk("reread_addr", mem_addr, 28'hC);
    step(0, 0, 30'h0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
